// File: rtl/float_divider_e4m3_if.sv
// Handshake bundle for the E4M3 divider.
//   start : request, sampled when the divider is not busy
//   a, b  : dividend / divisor, E4M3 {sign, exp[3:0], mant[2:0]}
//   y     : quotient, E4M3, held from valid until the next accepted start
//   valid : one-cycle pulse, y holds a new result
//   busy  : operation in flight, start ignored
interface float_divider_e4m3_if;
  logic       start;
  logic [7:0] a;
  logic [7:0] b;
  logic [7:0] y;
  logic       valid;
  logic       busy;

  modport master (output start, a, b, input y, valid, busy);
  modport slave  (input start, a, b, output y, valid, busy);
endinterface

// File: rtl/float_divider_e4m3.sv
// Multi-cycle E4M3 floating-point divider (restoring mantissa division,
// truncating, saturating, no subnormal outputs).
//   clock : rising-edge clock
//   reset : asynchronous, active-high
//   bus   : float_divider_e4m3_if.slave (start, a, b in; y, valid, busy out)
// Fixed latency: start accepted at edge k -> valid in the cycle after edge k+6.
module float_divider_e4m3 #(
  parameter int BIAS      = 7,
  parameter int DIV_STEPS = 5
) (
  input  logic                  clock,
  input  logic                  reset,
  float_divider_e4m3_if.slave   bus
);

  typedef enum logic [1:0] {IDLE, DIV, NORM, DONE} state_t;

  localparam int CW = $clog2(DIV_STEPS + 1);

  state_t        state_q, state_d;
  logic [7:0]    a_q, a_d;
  logic [7:0]    b_q, b_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [4:0]    rem_q, rem_d;
  logic [4:0]    quo_q, quo_d;
  logic [7:0]    y_q, y_d;
  logic          valid_q, valid_d;
  logic          busy_q, busy_d;

  // Result formation from the latched operands and the finished quotient.
  logic               sign;
  logic               nan_in;
  logic signed [6:0]  exp_raw;
  logic signed [6:0]  exp_n;
  logic [2:0]         mant_n;
  logic [7:0]         result;

  always_comb begin
    sign    = a_q[7] ^ b_q[7];
    nan_in  = (a_q[6:0] == 7'h7F) || (b_q[6:0] == 7'h7F);
    exp_raw = 7'(a_q[6:3]) - 7'(b_q[6:3]) + 7'(BIAS);
    if (quo_q[4]) begin
      mant_n = quo_q[3:1];
      exp_n  = exp_raw;
    end else begin
      mant_n = quo_q[2:0];
      exp_n  = exp_raw - 7'sd1;
    end

    if (nan_in)
      result = 8'h7F;
    else if (b_q[6:3] == 4'd0)
      result = 8'h7F;
    else if (a_q[6:3] == 4'd0)
      result = {sign, 7'd0};
    else if ((exp_n > 7'sd15) || ((exp_n == 7'sd15) && (mant_n == 3'b111)))
      result = {sign, 7'h7E};
    else if (exp_n < 7'sd1)
      result = {sign, 7'd0};
    else
      result = {sign, exp_n[3:0], mant_n};
  end

  // One restoring step: subtract when the remainder covers the divisor,
  // then shift; 5 bits suffice since the remainder stays below 16 pre-shift.
  logic [4:0] mb_ext;
  logic       step_ge;
  logic [4:0] step_rem;

  always_comb begin
    mb_ext   = {2'b01, b_q[2:0]};
    step_ge  = (rem_q >= mb_ext);
    step_rem = step_ge ? (rem_q - mb_ext) : rem_q;
  end

  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    y_d     = y_q;
    valid_d = 1'b0;
    busy_d  = busy_q;

    unique case (state_q)
      IDLE, DONE: begin
        if (bus.start) begin
          a_d     = bus.a;
          b_d     = bus.b;
          cnt_d   = '0;
          rem_d   = {2'b01, bus.a[2:0]};
          quo_d   = '0;
          state_d = DIV;
          busy_d  = 1'b1;
        end else begin
          state_d = IDLE;
        end
      end
      DIV: begin
        rem_d = {step_rem[3:0], 1'b0};
        quo_d = {quo_q[3:0], step_ge};
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(DIV_STEPS - 1))
          state_d = NORM;
      end
      NORM: begin
        y_d     = result;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = DONE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      cnt_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      y_q     <= '0;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      y_q     <= y_d;
      valid_q <= valid_d;
      busy_q  <= busy_d;
    end
  end

  assign bus.y     = y_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;

endmodule
